// File: rtl/debounce_pkg.sv
// Shared state encoding and width helper for the debounce bank.
// Pure declarations: no latency, no backpressure.
package debounce_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    W1 = 2'b01,
    S1 = 2'b10,
    W0 = 2'b11
  } state_t;

  // Counter width that still gives one bit when only a single value is needed.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, qualification FSM, registered rise/fall pulses.
// db follows a clean input after SYNC_STAGES+2 clocks plus STABLE_TICKS-1 tick periods; no backpressure.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic in,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      state  <= S0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rise   <= (state == W1) && (state_nxt == S1);
      fall   <= (state == W0) && (state_nxt == S0);
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // A bounce is tested before the tick so a bounce in a tick clock discards that tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S0: begin
        if (sync_in) begin
          state_nxt = W1;
          cnt_nxt   = '0;
        end
      end
      W1: begin
        if (!sync_in) begin
          state_nxt = S0;
        end else if (tick) begin
          if (cnt == CNT_LAST) state_nxt = S1;
          else                 cnt_nxt   = cnt + 1'b1;
        end
      end
      S1: begin
        if (!sync_in) begin
          state_nxt = W0;
          cnt_nxt   = '0;
        end
      end
      W0: begin
        if (sync_in) begin
          state_nxt = S1;
        end else if (tick) begin
          if (cnt == CNT_LAST) state_nxt = S0;
          else                 cnt_nxt   = cnt + 1'b1;
        end
      end
      default: state_nxt = S0;
    endcase
  end

  assign db = (state == S1) || (state == W0);

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer sharing one registered sample tick across all channels.
// tick rises TICK_DIV clocks after reset release; channels are independent; no backpressure.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] db,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int PW = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  // tick is registered off the wrap, so it is clean during reset and glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      tick    <= (pre_cnt == PRE_LAST);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .in    (in[i]),
      .db    (db[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: nominal (TICK_DIV=4, STABLE_TICKS=3) and boundary (1,1) instances share stimulus.
// A tick-counting reference model predicts every output each clock.
module tb_debounce_bank;

  localparam int TD [2] = '{4, 1};
  localparam int ST [2] = '{3, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_v;
  logic [3:0] db_a, rise_a, fall_a, db_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  debounce_bank #(.CHANNELS(4), .TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .in(in_v), .db(db_a), .rise(rise_a), .fall(fall_a), .tick(tick_a));

  debounce_bank #(.CHANNELS(4), .TICK_DIV(1), .STABLE_TICKS(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .in(in_v), .db(db_b), .rise(rise_b), .fall(fall_b), .tick(tick_b));

  always #5 clk = ~clk;

  // Reference model: db flips once STABLE_TICKS ticks have been seen while the
  // synchronised input disagrees with db, not counting the clock the disagreement starts.
  logic [3:0] m_db [2], m_rise [2], m_fall [2];
  bit         m_wait [2][4];
  int         m_ticks [2][4];
  int         m_cyc [2];
  bit         m_tick [2];
  logic [3:0] m_s1, m_s2;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_db[c] = '0; m_rise[c] = '0; m_fall[c] = '0;
      m_cyc[c] = 0; m_tick[c] = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        m_wait[c][ch] = 1'b0; m_ticks[c][ch] = 0;
      end
    end
    m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = '0; m_fall[c] = '0;
      for (int ch = 0; ch < 4; ch++) begin
        if (m_s2[ch] == m_db[c][ch]) begin
          m_wait[c][ch] = 1'b0;
        end else if (!m_wait[c][ch]) begin
          m_wait[c][ch] = 1'b1; m_ticks[c][ch] = 0;
        end else if (m_tick[c]) begin
          m_ticks[c][ch]++;
          if (m_ticks[c][ch] == ST[c]) begin
            m_db[c][ch] = ~m_db[c][ch];
            if (m_db[c][ch]) m_rise[c][ch] = 1'b1;
            else             m_fall[c][ch] = 1'b1;
            m_wait[c][ch] = 1'b0;
          end
        end
      end
      m_cyc[c]++;
      m_tick[c] = (m_cyc[c] % TD[c] == 0);
    end
    m_s2 = m_s1;
    m_s1 = in_v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_db",   32'(db_a),   32'(m_db[0]));
    chk("a_rise", 32'(rise_a), 32'(m_rise[0]));
    chk("a_fall", 32'(fall_a), 32'(m_fall[0]));
    chk("a_tick", 32'(tick_a), 32'(m_tick[0]));
    chk("b_db",   32'(db_b),   32'(m_db[1]));
    chk("b_rise", 32'(rise_b), 32'(m_rise[1]));
    chk("b_fall", 32'(fall_b), 32'(m_fall[1]));
    chk("b_tick", 32'(tick_b), 32'(m_tick[1]));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else       model_reset();
    #1;
    check_outputs();
  endtask

  int lat_a, lat_b, nr_a, nr_b, nf_a, nf_b, first_tick, bad, ticks_low;

  initial begin
    reset = 1'b0;
    in_v  = 4'hF;
    model_reset();

    // Reset values with all inputs high
    repeat (3) step();
    reset = 1'b1;
    first_tick = -1; lat_a = -1; lat_b = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick_a && first_tick < 0) first_tick = k;
      if (db_a == 4'hF && lat_a < 0) lat_a = k;
      if (db_b == 4'hF && lat_b < 0) lat_b = k;
    end
    chk("rst_first_tick", 32'(first_tick), 32'd4);
    chk("rst_lat_a_range", 32'(lat_a >= 12 && lat_a <= 15), 32'd1);
    chk("rst_lat_b", 32'(lat_b), 32'd4);

    // Clean press and release on channel 0
    in_v = 4'h0;
    repeat (20) step();
    in_v = 4'b0001;
    lat_a = -1; lat_b = -1; nr_a = 0; nr_b = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (db_a[0] && lat_a < 0) lat_a = k;
      if (db_b[0] && lat_b < 0) lat_b = k;
      if (rise_a[0]) nr_a++;
      if (rise_b[0]) nr_b++;
    end
    chk("press_lat_a_range", 32'(lat_a >= 12 && lat_a <= 15), 32'd1);
    chk("press_rise_a_count", 32'(nr_a), 32'd1);
    chk("press_lat_b", 32'(lat_b), 32'd4);
    chk("press_rise_b_count", 32'(nr_b), 32'd1);
    in_v = 4'b0000;
    lat_a = -1; nf_a = 0; nf_b = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!db_a[0] && lat_a < 0) lat_a = k;
      if (fall_a[0]) nf_a++;
      if (fall_b[0]) nf_b++;
    end
    chk("release_lat_a_range", 32'(lat_a >= 12 && lat_a <= 15), 32'd1);
    chk("release_fall_a_count", 32'(nf_a), 32'd1);
    chk("release_fall_b_count", 32'(nf_b), 32'd1);

    // Bounce on channel 1, then a clean hold
    bad = 0;
    for (int k = 0; k < 42; k++) begin
      in_v[1] = ((k / 3) % 2 == 0);
      step();
      if (db_a[1] || rise_a[1] || fall_a[1]) bad++;
    end
    chk("bounce_quiet_a", 32'(bad), 32'd0);
    in_v[1] = 1'b1;
    lat_a = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (db_a[1] && lat_a < 0) lat_a = k;
    end
    chk("bounce_hold_lat_range", 32'(lat_a >= 12 && lat_a <= 15), 32'd1);

    // 7-clock glitch on channel 2 (nominal instance must ignore it)
    in_v = 4'b0000;
    repeat (20) step();
    bad = 0;
    in_v[2] = 1'b1;
    repeat (7) begin step(); if (db_a[2] || rise_a[2] || fall_a[2]) bad++; end
    in_v[2] = 1'b0;
    repeat (20) begin step(); if (db_a[2] || rise_a[2] || fall_a[2]) bad++; end
    chk("glitch_quiet_a", 32'(bad), 32'd0);

    // 1-clock glitch on the boundary instance is still rejected
    bad = 0;
    in_v[0] = 1'b1;
    step();
    in_v[0] = 1'b0;
    repeat (10) begin step(); if (db_b[0] || rise_b[0] || fall_b[0]) bad++; end
    chk("glitch1_quiet_b", 32'(bad), 32'd0);

    // Randomised inputs, checked every clock against the model
    ticks_low = 0;
    for (int k = 0; k < 600; k++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 11) == 0) in_v[ch] = ~in_v[ch];
      step();
      if (!tick_b) ticks_low++;
    end
    chk("tick_b_always_high", 32'(ticks_low), 32'd0);

    // Mid-operation reset on channel 3
    in_v = 4'b0000;
    repeat (20) step();
    in_v = 4'b1000;
    repeat (10) step();
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_db_a", 32'(db_a), 32'd0);
    chk("midrst_tick_a", 32'(tick_a), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    lat_a = -1; nr_a = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (db_a[3] && lat_a < 0) lat_a = k;
      if (rise_a[3]) begin
        nr_a++;
        if (lat_a != k) bad++;
      end
    end
    chk("midrst_lat_range", 32'(lat_a >= 12 && lat_a <= 15), 32'd1);
    chk("midrst_rise_count", 32'(nr_a), 32'd1);
    chk("midrst_rise_aligned", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
